// File: rtl/multi_clock_divider.sv
// N-channel programmable square-wave/tick generator. Half-period counts come from
// one shared restoring divider that is time-shared round-robin across channels.
module multi_clock_divider #(
  parameter int CLK_HZ = 50_000_000,
  parameter int N_CH   = 4,
  parameter int FREQ_W = 20,
  parameter int CNT_W  = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH*FREQ_W-1:0]   freq,
  output logic [N_CH-1:0]          out_clk,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          valid,
  output logic                     busy
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IW = $clog2(CNT_W + 1);
  localparam int DW = CNT_W + 1;
  localparam logic [CNT_W:0] DIVIDEND = DW'(CLK_HZ);

  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_ITER, D_WB} div_state_t;
  typedef enum logic {C_IDLE, C_RUN} ch_state_t;

  div_state_t          div_state;
  ch_state_t           ch_state [N_CH];

  logic [FREQ_W-1:0]   f      [N_CH];
  logic [FREQ_W-1:0]   cur_f  [N_CH];
  logic [CNT_W-1:0]    half   [N_CH];
  logic [CNT_W-1:0]    pend   [N_CH];
  logic [CNT_W-1:0]    cnt    [N_CH];
  logic [N_CH-1:0]     pflag;

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       pick;
  logic                found;
  logic                zero_hit;
  logic                wb;
  logic [CNT_W-1:0]    wq;

  logic [FREQ_W:0]     dvsr;
  logic [FREQ_W:0]     rem;
  logic [CNT_W-1:0]    quo;
  logic [IW-1:0]       iter;
  logic [FREQ_W+1:0]   trial;
  logic [FREQ_W+1:0]   diff;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign f[g] = freq[g*FREQ_W +: FREQ_W];
  end

  // First channel at or after ptr whose request is stale or never computed.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx -= N_CH;
      if (!found && ((f[idx] != cur_f[idx]) || (!valid[idx] && (f[idx] != '0)))) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign zero_hit = (div_state == D_IDLE) && found && (f[pick] == '0);
  assign busy     = (div_state != D_IDLE);
  assign wb       = (div_state == D_WB);
  assign wq       = (quo == '0) ? CNT_W'(1) : quo;
  // Remainder shifts in the next dividend bit from the top of quo.
  assign trial    = {rem, quo[CNT_W-1]};
  assign diff     = trial - {1'b0, dvsr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_state <= D_IDLE;
      ptr       <= '0;
      sel       <= '0;
      dvsr      <= '0;
      rem       <= '0;
      quo       <= '0;
      iter      <= '0;
      valid     <= '0;
      for (int i = 0; i < N_CH; i++) cur_f[i] <= '0;
    end else begin
      case (div_state)
        D_IDLE: begin
          if (found) begin
            cur_f[pick] <= f[pick];
            ptr         <= (pick == PW'(N_CH - 1)) ? '0 : pick + 1'b1;
            if (f[pick] == '0) begin
              valid[pick] <= 1'b1;
            end else begin
              valid[pick] <= 1'b0;
              sel         <= pick;
              div_state   <= D_LOAD;
            end
          end
        end
        D_LOAD: begin
          dvsr      <= {cur_f[sel], 1'b0};
          rem       <= {{FREQ_W{1'b0}}, DIVIDEND[CNT_W]};
          quo       <= DIVIDEND[CNT_W-1:0];
          iter      <= '0;
          div_state <= D_ITER;
        end
        D_ITER: begin
          if (trial >= {1'b0, dvsr}) begin
            rem <= diff[FREQ_W:0];
            quo <= {quo[CNT_W-2:0], 1'b1};
          end else begin
            rem <= trial[FREQ_W:0];
            quo <= {quo[CNT_W-2:0], 1'b0};
          end
          iter <= iter + 1'b1;
          if (iter == IW'(CNT_W - 1)) div_state <= D_WB;
        end
        D_WB: begin
          valid[sel] <= 1'b1;
          div_state  <= D_IDLE;
        end
        default: div_state <= D_IDLE;
      endcase
    end
  end

  // Channel counters; a writeback landing on a boundary applies one boundary later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_clk <= '0;
      tick    <= '0;
      pflag   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ch_state[i] <= C_IDLE;
        half[i]     <= '0;
        pend[i]     <= '0;
        cnt[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        tick[i] <= 1'b0;
        case (ch_state[i])
          C_IDLE: begin
            out_clk[i] <= 1'b0;
            cnt[i]     <= '0;
            if (pflag[i]) begin
              half[i]  <= pend[i];
              pflag[i] <= 1'b0;
            end
            if (en[i] && valid[i] && (cur_f[i] != '0)) ch_state[i] <= C_RUN;
          end
          C_RUN: begin
            if (!en[i] || (cur_f[i] == '0)) begin
              ch_state[i] <= C_IDLE;
              out_clk[i]  <= 1'b0;
              cnt[i]      <= '0;
            end else if (cnt[i] == half[i] - CNT_W'(1)) begin
              cnt[i]     <= '0;
              out_clk[i] <= ~out_clk[i];
              tick[i]    <= ~out_clk[i];
              if (pflag[i]) begin
                half[i]  <= pend[i];
                pflag[i] <= 1'b0;
              end
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: ch_state[i] <= C_IDLE;
        endcase
        if (wb && (sel == PW'(i))) begin
          pend[i]  <= wq;
          pflag[i] <= 1'b1;
        end
        if (zero_hit && (pick == PW'(i))) pflag[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider at CLK_HZ=1000, two channels: directed frequency
// scenarios with a per-channel event scoreboard of high times and tick spacing.
module tb_multi_clock_divider;

  localparam int CLK_HZ = 1000;
  localparam int N_CH   = 2;
  localparam int FREQ_W = 10;
  localparam int CNT_W  = 10;

  logic                   clk;
  logic                   rst;
  logic [N_CH-1:0]        en;
  logic [N_CH*FREQ_W-1:0] freq;
  logic [N_CH-1:0]        out_clk;
  logic [N_CH-1:0]        tick;
  logic [N_CH-1:0]        valid;
  logic                   busy;

  int tests = 0;
  int fails = 0;

  // Event encoding: bit 15 set = tick spacing, clear = high time; low bits = cycles.
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  bit arm    [N_CH];
  bit seen   [N_CH];
  bit in_hi  [N_CH];
  bit prev_o [N_CH];
  int hi_cnt [N_CH];
  int tk_cnt [N_CH];

  multi_clock_divider #(
    .CLK_HZ (CLK_HZ),
    .N_CH   (N_CH),
    .FREQ_W (FREQ_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .freq    (freq),
    .out_clk (out_clk),
    .tick    (tick),
    .valid   (valid),
    .busy    (busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input int c, input logic k, input int len);
    logic [15:0] e;
    e = {k, 15'(len)};
    if (c == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic compare_ev(input int c, input logic k, input int len);
    logic [15:0] g;
    logic [15:0] e;
    bit          empty;
    g     = {k, 15'(len)};
    empty = (c == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
    tests++;
    if (empty) begin
      fails++;
      $display("FAIL ch%0d unexpected_event: got %s=%0d expected none", c,
               k ? "tick_gap" : "high_time", len);
    end else begin
      if (c == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if (e != g) begin
        fails++;
        $display("FAIL ch%0d event: got %s=%0d expected %s=%0d", c,
                 g[15] ? "tick_gap" : "high_time", g[14:0],
                 e[15] ? "tick_gap" : "high_time", e[14:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic sample_ch(input int c);
    logic o;
    logic t;
    logic rise;
    o    = out_clk[c];
    t    = tick[c];
    rise = o && !prev_o[c];
    if (!arm[c]) begin
      seen[c]   = 1'b0;
      in_hi[c]  = 1'b0;
      tk_cnt[c] = 0;
    end else begin
      if (t || rise) begin
        tests++;
        if (t != rise) begin
          fails++;
          $display("FAIL ch%0d tick_align: got tick=%0b expected %0b", c, t, rise);
        end
      end
      tk_cnt[c]++;
      if (t) begin
        if (seen[c]) compare_ev(c, 1'b1, tk_cnt[c]);
        seen[c]   = 1'b1;
        tk_cnt[c] = 0;
      end
      if (rise) begin
        in_hi[c]  = 1'b1;
        hi_cnt[c] = 1;
      end else if (o) begin
        hi_cnt[c]++;
      end else if (prev_o[c] && in_hi[c]) begin
        compare_ev(c, 1'b0, hi_cnt[c]);
        in_hi[c] = 1'b0;
      end
    end
    prev_o[c] = o;
  endtask

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < N_CH; c++) sample_ch(c);
  end

  // ---------------- driver tasks ----------------
  task automatic set_freq(input int c, input int val);
    freq[c*FREQ_W +: FREQ_W] = FREQ_W'(val);
  endtask

  task automatic wait_valid(input int c, output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (valid[c]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_tick(input int c, output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (tick[c]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < budget) begin
      if (exp_q0.size() == 0) arm[0] = 1'b0;
      if (exp_q1.size() == 0) arm[1] = 1'b0;
      @(negedge clk);
      k++;
    end
    arm[0] = 1'b0;
    arm[1] = 1'b0;
    check("drain_ch0_left", exp_q0.size(), 0);
    check("drain_ch1_left", exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int lat0;
    int lat1;
    int cnt_a;
    int cnt_b;

    rst  = 1'b1;
    en   = '0;
    freq = '0;
    repeat (2) @(negedge clk);
    check("rst_out_clk", int'(out_clk), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // 100 Hz: half = 1000/200 = 5; one edge to pick, then CNT_W+2 to valid.
    @(negedge clk);
    set_freq(0, 100);
    en[0] = 1'b1;
    wait_valid(0, n);
    check("lat_100", n, CNT_W + 3);
    wait_tick(0, n);
    check("first_rise_100", n, 6);
    check("ch1_unused_valid", int'(valid[1]), 0);
    arm[0] = 1'b1;
    push(0, 1'b0, 5); push(0, 1'b1, 10); push(0, 1'b0, 5); push(0, 1'b1, 10); push(0, 1'b0, 5);
    drain(200);

    // 100 -> 50 Hz right after a rise: old high completes, new half 10 from the next boundary.
    wait_tick(0, n);
    arm[0] = 1'b1;
    wait_tick(0, n);
    set_freq(0, 50);
    push(0, 1'b0, 5);  push(0, 1'b1, 10); push(0, 1'b0, 5); push(0, 1'b1, 15);
    push(0, 1'b0, 10); push(0, 1'b1, 20); push(0, 1'b0, 10);
    drain(300);

    // 600 Hz exceeds CLK_HZ/2: quotient 0 clamps to half 1.
    set_freq(0, 600);
    wait_valid(0, n);
    check("lat_600", n, CNT_W + 3);
    repeat (30) @(negedge clk);
    arm[0] = 1'b1;
    push(0, 1'b0, 1); push(0, 1'b1, 2); push(0, 1'b0, 1); push(0, 1'b1, 2); push(0, 1'b0, 1);
    drain(100);

    // freq 0: idle, valid, no ticks, no divider use.
    set_freq(0, 0);
    repeat (3) @(negedge clk);
    check("zero_out_clk", int'(out_clk[0]), 0);
    check("zero_valid", int'(valid[0]), 1);
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick[0]) cnt_a++;
      if (out_clk[0] || busy) cnt_b++;
    end
    check("zero_ticks", cnt_a, 0);
    check("zero_high_or_busy", cnt_b, 0);

    // en 1->0->1 while running at 100 Hz.
    set_freq(0, 100);
    wait_valid(0, n);
    check("lat_100_again", n, CNT_W + 3);
    wait_tick(0, n);
    repeat (2) @(negedge clk);
    check("en_pre_high", int'(out_clk[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    check("en_off_low", int'(out_clk[0]), 0);
    cnt_b = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || !valid[0] || out_clk[0]) cnt_b++;
    end
    check("en_off_quiet", cnt_b, 0);
    en[0] = 1'b1;
    wait_tick(0, n);
    check("en_on_first_rise", n, 6);
    check("en_on_valid", int'(valid[0]), 1);
    check("en_on_busy", int'(busy), 0);

    // Reset mid-divide (ch1 computing) while ch0 is high.
    wait_tick(0, n);
    set_freq(1, 125);
    en[1] = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_high", int'(out_clk[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_clk", int'(out_clk), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Both channels pending after reset: ch0 then ch1, busy 2*(CNT_W+2) cycles.
    lat0  = -1;
    lat1  = -1;
    cnt_a = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid[0] && lat0 < 0) lat0 = k;
      if (valid[1] && lat1 < 0) lat1 = k;
      if (busy) cnt_a++;
    end
    check("both_lat_ch0", lat0, CNT_W + 3);
    check("both_lat_ch1", lat1, 2 * (CNT_W + 2) + 2);
    check("both_busy_cycles", cnt_a, 2 * (CNT_W + 2));
    arm[0] = 1'b1;
    arm[1] = 1'b1;
    push(0, 1'b0, 5); push(0, 1'b1, 10); push(0, 1'b0, 5); push(0, 1'b1, 10);
    push(1, 1'b0, 4); push(1, 1'b1, 8);  push(1, 1'b0, 4); push(1, 1'b1, 8);
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised N-channel programmable clock generator. Each channel produces a 50 % square wave and a single-cycle rising-edge tick at a runtime-selected frequency in Hz, derived from the system clock. Half-period counts come from one shared sequential restoring divider, so there is no combinational divide. New frequencies take effect glitch-free at the next channel toggle. The block drives blink, audio-tone and scan-rate timing in the lab designs.

## Interface
- CLK_HZ, 50_000_000: system clock frequency in Hz (dividend).
- N_CH, 4: number of channels, 1..16.
- FREQ_W, 20: width of each requested-frequency field.
- CNT_W, 26: counter and quotient width; requires 2^CNT_W > CLK_HZ/2.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  N_CH  per-channel enable.
- freq  in  N_CH*FREQ_W  requested Hz; channel i occupies bits [i*FREQ_W +: FREQ_W]; 0 means idle.
- out_clk  out  N_CH  registered square outputs.
- tick  out  N_CH  one-cycle pulse coincident with each out_clk rise.
- valid  out  N_CH  channel has a computed half-period for its current freq.
- busy  out  1  shared divider computing.

## Operation
- Per channel, the block stores: latched freq (cur_f), active half-period (half), pending half-period (pend) with a pending flag (pflag), and a counter cnt.
- Scheduler (divider idle):
  - Scan channels round-robin starting after the last one served.
  - Pick the first channel whose freq input differs from cur_f, or whose valid is 0 with nonzero freq.
  - Latch freq into cur_f, clear valid, start the divider.
- Divider:
  - Quotient = CLK_HZ / (2*freq), truncated; divisor is FREQ_W+1 bits.
  - Load takes 1 cycle, then CNT_W iteration cycles (one quotient bit per cycle), then a 1-cycle writeback.
  - Result is clamped: quotient 0 becomes 1 (freq > CLK_HZ/2 gives toggling every cycle).
  - Writeback stores pend and sets pflag and valid.
  - freq == 0 skips the divider: cur_f is latched, pflag cleared, valid set, and the channel goes idle.
  - If freq changes again mid-computation, the current result is still written; the mismatch triggers a fresh computation on a later scan.
- Channel counter FSM, states IDLE and RUN:
  - IDLE (rst, en=0, cur_f=0, or never valid): out_clk=0, tick=0, cnt=0. A pending value moves into half immediately. Enter RUN when en=1, valid=1 and cur_f!=0.
  - RUN:
    - cnt increments each cycle.
    - When cnt == half-1: cnt goes to 0 and out_clk toggles; on a 0->1 toggle, tick=1 for that cycle.
    - At that same boundary, if pflag is set, half takes pend and pflag clears. This gives glitch-free reload.
  - Leaving RUN (en falls or cur_f becomes 0): next edge goes to IDLE; out_clk=0, cnt=0, no tick.
- Reset values: out_clk=0, tick=0, valid=0, busy=0. All cur_f, half, pend, pflag and cnt are 0. Scan pointer is 0.
- Reset mid-computation aborts the divide; no writeback occurs.

## Timing
- Divide latency: CNT_W+2 cycles from start to valid.
- Worst-case valid after a stable freq change: N_CH*(CNT_W+2)+1 cycles.
- First rise after entering RUN: out_clk rises on the half-th edge after the RUN entry edge. tick rises on the same edge.
- Steady state: period is 2*half cycles, high time is half cycles, and ticks are spaced 2*half cycles apart.
- half=1: out_clk toggles every cycle and tick fires every 2 cycles.
- en deassertion: out_clk is low one edge later; any partial high phase is truncated, which is accepted behaviour.
- Simultaneous writeback and boundary on the same channel: the boundary uses the old half; the new half applies at the following boundary.

## Test plan
- CLK_HZ=1000, CNT_W=10, N_CH=2. ch0 freq=100, en=1 after reset → valid within 12 cycles. out_clk is high 5 cycles, low 5 cycles, tick every 10 cycles.
- ch0 running at 100 Hz, change freq to 50 → the current half-period completes at 5 cycles, then high/low of 10 cycles each with no runt pulse.
- freq=600 (> CLK_HZ/2) → half clamps to 1, out_clk toggles every cycle, tick every 2 cycles. freq=0 → out_clk=0, valid=1, no ticks.
- Both channels change freq on the same cycle → busy is held ~24 cycles. ch0 is served first, then ch1. Both valid, each with its correct period.
- rst asserted mid-divide and during out_clk high → all outputs are 0 asynchronously. After release, recomputation starts and output matches a fresh start.
- en toggled 1→0→1 while running → out_clk is low one edge after en falls. On re-enable, the first rise comes half cycles later with no recompute, and valid stays 1.
